// File: rtl/mc_control_unit.sv
// -----------------------------------------------------------------------------
// mc_control_unit
//
// Multicycle control FSM for the 16-bit RISC datapath. Sequences each
// instruction through FETCH / DECODE / EXECUTE / MEM / WB and drives the
// datapath strobes from the current state. FETCH, MEM_RD and MEM_WR stall
// on mem_ready. A wait counter traps the unit if a stall lasts too long.
// The unit also provides HALT, an illegal-opcode trap and a retire counter.
//
// Parameters
//   OPCODE_W  opcode width (>= 4); any set bit above bit 3 is illegal
//   CNT_W     retire counter width
//   MAX_WAIT  consecutive mem_ready-low cycles tolerated per memory state
//             before trapping; 0 disables the timeout
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   opcode           instruction opcode, sampled in DECODE only
//   zero             ALU zero flag (informational; branch gating is in the
//                    datapath)
//   mem_ready        acknowledge for the current IM/DM access
//   PC_Sel .. PC_Wr_Cond, ALU_Src_A, ALU_Src_B   datapath strobes
//   p_state          current state encoding
//   retire           pulse in the last cycle of each completed instruction
//   retire_cnt       wrapping count of retired instructions
//   halted, trap     sticky status (HALT / TRAP are absorbing until rst)
//   trap_cause       00 none, 01 illegal opcode, 10 memory timeout
// -----------------------------------------------------------------------------
module mc_control_unit #(
   parameter int OPCODE_W = 4,
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                PC_Sel,
   output logic                PC_Wr,
   output logic                IM_Read,
   output logic                DM_Read,
   output logic                DM_Wr,
   output logic                Reg_Dst,
   output logic                Mem_to_Reg,
   output logic                Reg_Wr,
   output logic                Data_Src,
   output logic                PC_Wr_Cond,
   output logic [1:0]          ALU_Src_A,
   output logic [2:0]          ALU_Src_B,
   output logic [3:0]          p_state,
   output logic                retire,
   output logic [CNT_W-1:0]    retire_cnt,
   output logic                halted,
   output logic                trap,
   output logic [1:0]          trap_cause
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_FETCH    = 4'd1;
   localparam logic [3:0] S_DECODE   = 4'd2;
   localparam logic [3:0] S_EXEC_R   = 4'd3;
   localparam logic [3:0] S_EXEC_I   = 4'd4;
   localparam logic [3:0] S_MEM_ADDR = 4'd5;
   localparam logic [3:0] S_MEM_RD   = 4'd6;
   localparam logic [3:0] S_WB_MEM   = 4'd7;
   localparam logic [3:0] S_MEM_WR   = 4'd8;
   localparam logic [3:0] S_WB_R     = 4'd9;
   localparam logic [3:0] S_WB_I     = 4'd10;
   localparam logic [3:0] S_BRANCH   = 4'd11;
   localparam logic [3:0] S_JUMP     = 4'd12;
   localparam logic [3:0] S_HALT     = 4'd13;
   localparam logic [3:0] S_TRAP     = 4'd14;

   localparam logic [1:0] TC_NONE    = 2'b00;
   localparam logic [1:0] TC_ILLEGAL = 2'b01;
   localparam logic [1:0] TC_TIMEOUT = 2'b10;

   localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

   logic [3:0]        state;
   logic [3:0]        next_state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              is_store;
   logic              in_mem;
   logic              timeout;
   logic              illegal_hi;
   logic              unused_zero;

   // The zero flag is consumed by the datapath's PC_Wr_Cond gate, not here.
   assign unused_zero = zero;

   assign in_mem     = (state == S_FETCH) || (state == S_MEM_RD) ||
                       (state == S_MEM_WR);
   assign illegal_hi = |(opcode >> 4);

   // The counter holds MAX_WAIT on the (MAX_WAIT+1)-th stalled cycle, so a
   // mem_ready that rises on that cycle still completes the access.
   assign timeout = (MAX_WAIT != 0) && in_mem && !mem_ready &&
                    (wait_cnt == WAIT_W'(MAX_WAIT));

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   next_state = S_FETCH;
         S_FETCH: begin
            if (timeout)        next_state = S_TRAP;
            else if (mem_ready) next_state = S_DECODE;
         end
         S_DECODE: begin
            if (illegal_hi) begin
               next_state = S_TRAP;
            end else begin
               case (opcode[3:0])
                  4'b0000, 4'b0001,
                  4'b0010, 4'b0011: next_state = S_EXEC_R;
                  4'b0100:          next_state = S_EXEC_I;
                  4'b0101, 4'b0110: next_state = S_MEM_ADDR;
                  4'b0111:          next_state = S_BRANCH;
                  4'b1000:          next_state = S_JUMP;
                  4'b1111:          next_state = S_HALT;
                  default:          next_state = S_TRAP;
               endcase
            end
         end
         S_EXEC_R:   next_state = S_WB_R;
         S_EXEC_I:   next_state = S_WB_I;
         // Opcode is only valid in DECODE, so LW/SW is resolved from the
         // flag captured there rather than from the live opcode.
         S_MEM_ADDR: next_state = is_store ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: begin
            if (timeout)        next_state = S_TRAP;
            else if (mem_ready) next_state = S_WB_MEM;
         end
         S_MEM_WR: begin
            if (timeout)        next_state = S_TRAP;
            else if (mem_ready) next_state = S_FETCH;
         end
         S_WB_R, S_WB_I, S_WB_MEM,
         S_BRANCH, S_JUMP:    next_state = S_FETCH;
         S_HALT:              next_state = S_HALT;
         S_TRAP:              next_state = S_TRAP;
         default:             next_state = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Retire detection: MEM_WR retires only on its acknowledged cycle
   // ------------------------------------------------------------------
   always_comb begin
      retire = 1'b0;
      case (state)
         S_WB_R, S_WB_I, S_WB_MEM,
         S_BRANCH, S_JUMP: retire = 1'b1;
         S_MEM_WR:         retire = mem_ready;
         default:          retire = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         is_store   <= 1'b0;
         retire_cnt <= '0;
         trap_cause <= TC_NONE;
      end else begin
         state <= next_state;

         if (state == S_DECODE)
            is_store <= (opcode[3:0] == 4'b0110);

         // Stall count is per memory state: any transition restarts it.
         if ((next_state != state) || mem_ready || !in_mem)
            wait_cnt <= '0;
         else if (wait_cnt != '1)
            wait_cnt <= wait_cnt + 1'b1;

         if (retire)
            retire_cnt <= retire_cnt + 1'b1;

         if ((state != S_TRAP) && (next_state == S_TRAP))
            trap_cause <= timeout ? TC_TIMEOUT : TC_ILLEGAL;
      end
   end

   // ------------------------------------------------------------------
   // State-decoded datapath strobes
   // ------------------------------------------------------------------
   always_comb begin
      PC_Sel     = 1'b0;
      PC_Wr      = 1'b0;
      IM_Read    = 1'b0;
      DM_Read    = 1'b0;
      DM_Wr      = 1'b0;
      Reg_Dst    = 1'b0;
      Mem_to_Reg = 1'b0;
      Reg_Wr     = 1'b0;
      Data_Src   = 1'b0;
      PC_Wr_Cond = 1'b0;
      ALU_Src_A  = 2'b00;
      ALU_Src_B  = 3'b000;
      case (state)
         S_FETCH: begin
            IM_Read   = 1'b1;
            ALU_Src_B = 3'b001;
            // PC advances only on the acknowledged fetch cycle.
            PC_Wr     = mem_ready;
         end
         S_DECODE: ALU_Src_B = 3'b011;
         S_EXEC_R: ALU_Src_A = 2'b01;
         S_EXEC_I, S_MEM_ADDR: begin
            ALU_Src_A = 2'b01;
            ALU_Src_B = 3'b010;
         end
         S_WB_R: begin
            Reg_Dst = 1'b1;
            Reg_Wr  = 1'b1;
         end
         S_WB_I:   Reg_Wr  = 1'b1;
         S_MEM_RD: DM_Read = 1'b1;
         S_WB_MEM: begin
            Mem_to_Reg = 1'b1;
            Reg_Wr     = 1'b1;
         end
         S_MEM_WR: begin
            DM_Wr    = 1'b1;
            Data_Src = 1'b1;
         end
         S_BRANCH: begin
            ALU_Src_A  = 2'b01;
            PC_Sel     = 1'b1;
            PC_Wr_Cond = 1'b1;
         end
         S_JUMP: begin
            ALU_Src_B = 3'b100;
            PC_Sel    = 1'b1;
            PC_Wr     = 1'b1;
         end
         default: ;
      endcase
   end

   assign p_state = state;
   assign halted  = (state == S_HALT);
   assign trap    = (state == S_TRAP);

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

   localparam int OW = 5;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [OW-1:0] opcode;
   logic          zero;
   logic          mem_ready;
   logic          PC_Sel, PC_Wr, IM_Read, DM_Read, DM_Wr, Reg_Dst;
   logic          Mem_to_Reg, Reg_Wr, Data_Src, PC_Wr_Cond;
   logic [1:0]    ALU_Src_A;
   logic [2:0]    ALU_Src_B;
   logic [3:0]    p_state;
   logic          retire;
   logic [15:0]   retire_cnt;
   logic          halted, trap;
   logic [1:0]    trap_cause;

   logic [3:0]    opcode_s;
   logic          mem_ready_s;
   logic          PC_Sel_s, PC_Wr_s, IM_Read_s, DM_Read_s, DM_Wr_s, Reg_Dst_s;
   logic          Mem_to_Reg_s, Reg_Wr_s, Data_Src_s, PC_Wr_Cond_s;
   logic [1:0]    ALU_Src_A_s;
   logic [2:0]    ALU_Src_B_s;
   logic [3:0]    p_state_s;
   logic          retire_s;
   logic [1:0]    retire_cnt_s;
   logic          halted_s, trap_s;
   logic [1:0]    trap_cause_s;

   mc_control_unit #(.OPCODE_W(OW), .CNT_W(16), .MAX_WAIT(3)) u_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .PC_Sel(PC_Sel), .PC_Wr(PC_Wr), .IM_Read(IM_Read), .DM_Read(DM_Read),
      .DM_Wr(DM_Wr), .Reg_Dst(Reg_Dst), .Mem_to_Reg(Mem_to_Reg), .Reg_Wr(Reg_Wr),
      .Data_Src(Data_Src), .PC_Wr_Cond(PC_Wr_Cond), .ALU_Src_A(ALU_Src_A),
      .ALU_Src_B(ALU_Src_B), .p_state(p_state), .retire(retire),
      .retire_cnt(retire_cnt), .halted(halted), .trap(trap), .trap_cause(trap_cause)
   );

   mc_control_unit #(.OPCODE_W(4), .CNT_W(2), .MAX_WAIT(0)) u_small (
      .clk(clk), .rst(rst), .opcode(opcode_s), .zero(zero), .mem_ready(mem_ready_s),
      .PC_Sel(PC_Sel_s), .PC_Wr(PC_Wr_s), .IM_Read(IM_Read_s), .DM_Read(DM_Read_s),
      .DM_Wr(DM_Wr_s), .Reg_Dst(Reg_Dst_s), .Mem_to_Reg(Mem_to_Reg_s),
      .Reg_Wr(Reg_Wr_s), .Data_Src(Data_Src_s), .PC_Wr_Cond(PC_Wr_Cond_s),
      .ALU_Src_A(ALU_Src_A_s), .ALU_Src_B(ALU_Src_B_s), .p_state(p_state_s),
      .retire(retire_s), .retire_cnt(retire_cnt_s), .halted(halted_s),
      .trap(trap_s), .trap_cause(trap_cause_s)
   );

   logic [14:0] strb, strb_s;
   assign strb   = {PC_Sel, PC_Wr, IM_Read, DM_Read, DM_Wr, Reg_Dst, Mem_to_Reg,
                    Reg_Wr, Data_Src, PC_Wr_Cond, ALU_Src_A, ALU_Src_B};
   assign strb_s = {PC_Sel_s, PC_Wr_s, IM_Read_s, DM_Read_s, DM_Wr_s, Reg_Dst_s,
                    Mem_to_Reg_s, Reg_Wr_s, Data_Src_s, PC_Wr_Cond_s,
                    ALU_Src_A_s, ALU_Src_B_s};

   // One instruction: stalls, expected latency (FETCH entry to retire
   // inclusive), state at retire, strobe-cycle counts and retire-cycle strobes.
   typedef struct {
      logic [3:0]  op;
      int unsigned f;
      int unsigned m;
      int unsigned lat;
      logic [3:0]  end_st;
      int unsigned reg_wr;
      int unsigned dm_rd;
      int unsigned dm_wr;
      int unsigned pc_wr;
      logic [14:0] end_strb;
   } vec_t;

   int unsigned vec_cnt = 0;
   int unsigned err_cnt = 0;
   logic [15:0] exp_rc;
   logic [3:0]  trace [32];
   vec_t        tbl [12];
   logic [3:0]  exp_add [4] = '{4'd1, 4'd2, 4'd3, 4'd9};
   logic [3:0]  exp_lw  [7] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd6, 4'd6, 4'd7};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Expected behaviour of one instruction from the published latencies.
   function automatic vec_t model(input logic [3:0] op, input int unsigned f,
                                  input int unsigned m);
      vec_t v;
      v.op = op; v.f = f; v.m = 0; v.reg_wr = 0; v.dm_rd = 0; v.dm_wr = 0;
      v.pc_wr = 1; v.lat = 0; v.end_st = 4'd0; v.end_strb = 15'h0;
      case (op)
         4'd0, 4'd1, 4'd2, 4'd3: begin
            v.lat = 4 + f; v.end_st = 4'd9;  v.reg_wr = 1; v.end_strb = 15'h0280;
         end
         4'd4: begin
            v.lat = 4 + f; v.end_st = 4'd10; v.reg_wr = 1; v.end_strb = 15'h0080;
         end
         4'd5: begin
            v.m = m; v.lat = 5 + f + m; v.end_st = 4'd7; v.reg_wr = 1;
            v.dm_rd = m + 1; v.end_strb = 15'h0180;
         end
         4'd6: begin
            v.m = m; v.lat = 4 + f + m; v.end_st = 4'd8; v.dm_wr = m + 1;
            v.end_strb = 15'h0440;
         end
         4'd7: begin
            v.lat = 3 + f; v.end_st = 4'd11; v.end_strb = 15'h4028;
         end
         default: begin
            v.lat = 3 + f; v.end_st = 4'd12; v.pc_wr = 2; v.end_strb = 15'h6004;
         end
      endcase
      return v;
   endfunction

   // Starts in the FETCH cycle (posedge+1); ends at posedge+1 of the next FETCH.
   task automatic run_vec(input vec_t v);
      int unsigned rw = 0, rd = 0, dw = 0, pw = 0;
      logic is_mem;
      is_mem = (v.op == 4'd5) || (v.op == 4'd6);
      for (int unsigned k = 0; k < v.lat; k++) begin
         if (k <= v.f)
            mem_ready = (k == v.f);
         else if (is_mem && k >= v.f + 3 && k <= v.f + 3 + v.m)
            mem_ready = (k == v.f + 3 + v.m);
         else
            mem_ready = 1'($urandom_range(0, 1));
         opcode = (k == v.f + 1) ? {1'b0, v.op} : OW'($urandom);
         zero   = 1'($urandom_range(0, 1));
         settle();
         if (k < 32) trace[k] = p_state;
         if (k == 0) begin
            check("fetch_entry", 32'(p_state), 32'd1);
            check("fetch_strobes", 32'(strb), (v.f == 0) ? 32'h3001 : 32'h1001);
         end
         rw += 32'(Reg_Wr); rd += 32'(DM_Read); dw += 32'(DM_Wr); pw += 32'(PC_Wr);
         if (k == v.lat - 1) begin
            check("retire_pulse", 32'(retire), 32'd1);
            check("retire_state", 32'(p_state), 32'(v.end_st));
            check("retire_strobes", 32'(strb), 32'(v.end_strb));
            exp_rc = exp_rc + 16'd1;
         end else begin
            check("no_early_retire", 32'(retire), 32'd0);
         end
         step();
      end
      check("retire_cnt", 32'(retire_cnt), 32'(exp_rc));
      check("reg_wr_cycles", rw, v.reg_wr);
      check("dm_rd_cycles", rd, v.dm_rd);
      check("dm_wr_cycles", dw, v.dm_wr);
      check("pc_wr_cycles", pw, v.pc_wr);
   endtask

   // Holds rst for several edges, releases it and leaves both DUTs at the
   // start of their first FETCH cycle.
   task automatic do_reset();
      rst = 1'b1; mem_ready = 1'b1; opcode = '0; zero = 1'b0;
      mem_ready_s = 1'b1; opcode_s = 4'd0;
      repeat (3) begin
         step();
         settle();
         check("rst_pstate", 32'(p_state), 32'd0);
         check("rst_strobes", 32'(strb), 32'd0);
         check("rst_status", 32'({retire, halted, trap, trap_cause}), 32'd0);
         check("rst_retire_cnt", 32'(retire_cnt), 32'd0);
      end
      check("rst_retire_cnt_small", 32'(retire_cnt_s), 32'd0);
      step();
      rst = 1'b0;
      settle();
      check("idle_pstate", 32'(p_state), 32'd0);
      check("idle_strobes", 32'(strb), 32'd0);
      step();
      exp_rc = '0;
   endtask

   // FETCH, DECODE with op, then five cycles in an absorbing state.
   task automatic decode_into(input logic [OW-1:0] op, input logic [3:0] st,
                              input logic [1:0] cause, input logic h, input logic t);
      mem_ready = 1'b1; opcode = OW'($urandom);
      settle();
      check("pre_fetch", 32'(p_state), 32'd1);
      step();
      opcode = op; mem_ready = 1'($urandom_range(0, 1));
      settle();
      check("pre_decode", 32'(p_state), 32'd2);
      step();
      for (int i = 0; i < 5; i++) begin
         opcode = OW'($urandom); mem_ready = 1'($urandom_range(0, 1));
         settle();
         check("absorb_state", 32'(p_state), 32'(st));
         check("absorb_status", 32'({halted, trap, trap_cause}), 32'({h, t, cause}));
         check("absorb_strobes", 32'(strb), 32'd0);
         check("absorb_retire", 32'(retire), 32'd0);
         check("absorb_retire_cnt", 32'(retire_cnt), 32'(exp_rc));
         step();
      end
   endtask

   initial begin
      rst = 1'b1; mem_ready = 1'b1; opcode = '0; zero = 1'b0;
      mem_ready_s = 1'b1; opcode_s = 4'd0; exp_rc = '0;

      //            op     f  m  lat end    rw rd dw pw strb
      tbl[0]  = '{4'd0,  0, 0, 4, 4'd9,  1, 0, 0, 1, 15'h0280};
      tbl[1]  = '{4'd5,  0, 2, 7, 4'd7,  1, 3, 0, 1, 15'h0180};
      tbl[2]  = '{4'd7,  0, 0, 3, 4'd11, 0, 0, 0, 1, 15'h4028};
      tbl[3]  = '{4'd8,  0, 0, 3, 4'd12, 0, 0, 0, 2, 15'h6004};
      tbl[4]  = '{4'd6,  1, 1, 6, 4'd8,  0, 0, 2, 1, 15'h0440};
      tbl[5]  = '{4'd4,  2, 0, 6, 4'd10, 1, 0, 0, 1, 15'h0080};
      tbl[6]  = '{4'd3,  3, 0, 7, 4'd9,  1, 0, 0, 1, 15'h0280};
      tbl[7]  = '{4'd5,  0, 3, 8, 4'd7,  1, 4, 0, 1, 15'h0180};
      tbl[8]  = '{4'd6,  0, 3, 7, 4'd8,  0, 0, 4, 1, 15'h0440};
      tbl[9]  = '{4'd1,  0, 0, 4, 4'd9,  1, 0, 0, 1, 15'h0280};
      tbl[10] = '{4'd2,  1, 0, 5, 4'd9,  1, 0, 0, 1, 15'h0280};
      tbl[11] = '{4'd7,  2, 0, 5, 4'd11, 0, 0, 0, 1, 15'h4028};

      do_reset();

      run_vec(tbl[0]);
      for (int i = 0; i < 4; i++) check("add_trace", 32'(trace[i]), 32'(exp_add[i]));
      run_vec(tbl[1]);
      for (int i = 0; i < 7; i++) check("lw_trace", 32'(trace[i]), 32'(exp_lw[i]));
      for (int i = 2; i < 12; i++) run_vec(tbl[i]);

      for (int i = 0; i < 150; i++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 8));
         run_vec(model(op, $urandom_range(0, 3), $urandom_range(0, 3)));
      end

      // HALT keeps the retire count untouched.
      decode_into(OW'(15), 4'd13, 2'b00, 1'b1, 1'b0);

      // Reset in the middle of an ADD aborts it without a write strobe.
      do_reset();
      run_vec(tbl[0]);
      mem_ready = 1'b1; settle(); step();
      opcode = '0; settle();
      check("mid_decode", 32'(p_state), 32'd2);
      step();
      settle();
      check("mid_exec", 32'(p_state), 32'd3);
      rst = 1'b1;
      step();
      settle();
      check("mid_rst_pstate", 32'(p_state), 32'd0);
      check("mid_rst_strobes", 32'(strb), 32'd0);
      check("mid_rst_retire_cnt", 32'(retire_cnt), 32'd0);

      do_reset();
      decode_into(OW'(10), 4'd14, 2'b01, 1'b0, 1'b1);
      do_reset();
      decode_into(OW'(16), 4'd14, 2'b01, 1'b0, 1'b1);

      // FETCH timeout: four stalled FETCH cycles, then TRAP.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         mem_ready = 1'b0;
         settle();
         if (k < 4) begin
            check("to_fetch_state", 32'(p_state), 32'd1);
            check("to_fetch_pcwr", 32'(PC_Wr), 32'd0);
         end else begin
            check("to_fetch_trap", 32'(p_state), 32'd14);
            check("to_fetch_cause", 32'({trap, trap_cause}), 32'b110);
         end
         step();
      end

      // MEM_WR timeout: SW whose store is never acknowledged.
      do_reset();
      run_vec(tbl[2]);
      mem_ready = 1'b1; settle(); step();
      opcode = OW'(6); settle(); step();
      settle(); check("to_sw_addr", 32'(p_state), 32'd5); step();
      for (int k = 0; k < 5; k++) begin
         mem_ready = 1'b0;
         settle();
         if (k < 4) begin
            check("to_sw_state", 32'(p_state), 32'd8);
            check("to_sw_retire", 32'(retire), 32'd0);
         end else begin
            check("to_sw_trap", 32'(p_state), 32'd14);
            check("to_sw_cause", 32'(trap_cause), 32'b10);
            check("to_sw_retire_cnt", 32'(retire_cnt), 32'(exp_rc));
         end
         step();
      end

      // Narrow counter wraps after five ADDs; MAX_WAIT=0 never times out.
      do_reset();
      repeat (20) step();
      settle();
      check("wrap_retire_cnt", 32'(retire_cnt_s), 32'd1);
      check("wrap_state", 32'(p_state_s), 32'd1);
      step();
      mem_ready_s = 1'b0;
      repeat (20) step();
      settle();
      check("nowait_state", 32'(p_state_s), 32'd1);
      check("nowait_status", 32'({retire_s, halted_s, trap_s, trap_cause_s}), 32'd0);
      check("nowait_strobes", 32'(strb_s), 32'h1001);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
